// File: rtl/riscv32_pkg.sv
// Shared RV32 loader definitions: word width, the HLT opcode and the loader
// state encoding used by program_loader and its checksum helper.
package riscv32_pkg;

  localparam int         WORD_W = 32;
  localparam logic [6:0] HLT_OP = 7'h7f;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    RELEASE,
    RUN,
    ERR
  } loader_state_e;

  function automatic logic is_hlt(input logic [WORD_W-1:0] word,
                                  input logic [6:0]        opcode);
    return word[WORD_W-1 -: 7] == opcode;
  endfunction

endpackage

// File: rtl/loader_cksum.sv
// Wrapping 32-bit running sum of accepted instruction words; exists only in
// builds with LOADER_CHECKSUM_EN defined.
`ifdef LOADER_CHECKSUM_EN
module loader_cksum
  import riscv32_pkg::*;
(
  input  logic              clk1,
  input  logic              rst,
  input  logic              clear,
  input  logic              add,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sum
);

  logic [WORD_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add) begin
      sum_d = sum_q + word;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule
`endif

// File: rtl/program_loader.sv
// Streams instruction words into instruction memory, then releases the core.
// Optional build macro LOADER_CHECKSUM_EN adds a checksum gate before release.
module program_loader
  import riscv32_pkg::*;
#(
  parameter int         ADDR_W     = 10,
  parameter logic [6:0] HLT_OPCODE = HLT_OP
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_hold,
  output logic              core_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  input  logic [WORD_W-1:0] expected_sum,
  output logic [WORD_W-1:0] checksum
`endif
);

  localparam logic [ADDR_W:0] WC_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] DEPTH  = WC_ONE << ADDR_W;

  loader_state_e     state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              core_hold_q, core_hold_d;
  logic              core_start_q, core_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic [ADDR_W:0]   wc_inc;
  logic              xfer;

  // in_ready_q is only ever high in LOAD, so it also gates in_valid elsewhere.
  assign xfer   = in_valid && in_ready_q;
  assign wc_inc = word_count_q + WC_ONE;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;

    unique case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_d      = LOAD;
          imem_addr_d  = '0;
          word_count_d = '0;
        end
      end
      LOAD: begin
        if (xfer) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = word_count_q[ADDR_W-1:0];
          imem_wdata_d = in_data;
          word_count_d = wc_inc;
          if (is_hlt(in_data, HLT_OPCODE)) begin
            state_d = DRAIN;
          end else if (wc_inc == DEPTH) begin
            state_d = ERR;
          end
        end
      end
      DRAIN: begin
`ifdef LOADER_CHECKSUM_EN
        state_d = (checksum != expected_sum) ? ERR : RELEASE;
`else
        state_d = RELEASE;
`endif
      end
      RELEASE: state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they land in registers.
  always_comb begin
    in_ready_d   = 1'b0;
    core_hold_d  = 1'b1;
    core_start_d = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_d)
      LOAD: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      DRAIN:   busy_d = 1'b1;
      RELEASE: begin
        busy_d       = 1'b1;
        core_hold_d  = 1'b0;
        core_start_d = 1'b1;
      end
      RUN: begin
        core_hold_d = 1'b0;
        done_d      = 1'b1;
      end
      ERR:     err_d = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the instruction memory itself is deliberately never cleared by rst;
  // a partial image stays in place and the next load simply overwrites it.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b1;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_hold_q  <= core_hold_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = word_count_q;

`ifdef LOADER_CHECKSUM_EN
  logic cksum_clear;
  logic cksum_add;

  assign cksum_clear = (state_d == LOAD) && (state_q != LOAD);
  assign cksum_add   = xfer;

  loader_cksum u_cksum (
    .clk1  (clk1),
    .rst   (rst),
    .clear (cksum_clear),
    .add   (cksum_add),
    .word  (in_data),
    .sum   (checksum)
  );
`endif

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a default-size instance and a 3-bit
// address instance; checksum cases build only with LOADER_CHECKSUM_EN.
module tb_program_loader;
  import riscv32_pkg::*;

  localparam int AW_A = 10;
  localparam int AW_B = 3;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  logic [1:0]      start    = '0;
  logic [1:0]      in_valid = '0;
  logic [31:0]     in_data [2];
  logic [1:0]      in_ready, imem_we, core_hold, core_start, busy, done, err;
  logic [AW_A-1:0] addr_a;
  logic [AW_B-1:0] addr_b;
  logic [31:0]     wdata [2];
  logic [AW_A:0]   wc_a;
  logic [AW_B:0]   wc_b;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     exp_sum [2];
  logic [31:0]     cks [2];
  logic [31:0]     sum_model [2];
`endif

  program_loader #(.ADDR_W(AW_A)) dut_a (
    .clk1(clk1), .rst(rst), .start(start[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .imem_we(imem_we[0]), .imem_addr(addr_a), .imem_wdata(wdata[0]),
    .core_hold(core_hold[0]), .core_start(core_start[0]),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .word_count(wc_a)
`ifdef LOADER_CHECKSUM_EN
    , .expected_sum(exp_sum[0]), .checksum(cks[0])
`endif
  );

  program_loader #(.ADDR_W(AW_B)) dut_b (
    .clk1(clk1), .rst(rst), .start(start[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .imem_we(imem_we[1]), .imem_addr(addr_b), .imem_wdata(wdata[1]),
    .core_hold(core_hold[1]), .core_start(core_start[1]),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .word_count(wc_b)
`ifdef LOADER_CHECKSUM_EN
    , .expected_sum(exp_sum[1]), .checksum(cks[1])
`endif
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  wr_t e_a, e_b;
  int  exp_addr[2] = '{0, 0};
  int  starts[2]   = '{0, 0};
  int  tests_run    = 0;
  int  tests_failed = 0;

  logic [31:0] prog10 [10] = '{
    32'h1400800a, 32'h14010014, 32'h1401801e, 32'h14020028, 32'h14028032,
    32'h1403003c, 32'h14038046, 32'h14040050, 32'h1404805a, 32'hfe000000
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitors: every imem write must match the head of its queue.
  always @(negedge clk1) begin
    if (core_start[0]) starts[0]++;
    if (imem_we[0]) begin
      if (q_a.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL write_a: unexpected write addr=%0d data=0x%08h", addr_a, wdata[0]);
      end else begin
        e_a = q_a.pop_front();
        check("write_addr_a", 32'(addr_a), e_a.addr);
        check("write_data_a", wdata[0], e_a.data);
      end
    end
  end

  always @(negedge clk1) begin
    if (core_start[1]) starts[1]++;
    if (imem_we[1]) begin
      if (q_b.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL write_b: unexpected write addr=%0d data=0x%08h", addr_b, wdata[1]);
      end else begin
        e_b = q_b.pop_front();
        check("write_addr_b", 32'(addr_b), e_b.addr);
        check("write_data_b", wdata[1], e_b.data);
      end
    end
  end

  function automatic logic [31:0] wc_of(input int k);
    return (k == 0) ? 32'(wc_a) : 32'(wc_b);
  endfunction

  function automatic logic [31:0] addr_of(input int k);
    return (k == 0) ? 32'(addr_a) : 32'(addr_b);
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pulse_start(input int k);
    exp_addr[k] = 0;
`ifdef LOADER_CHECKSUM_EN
    sum_model[k] = '0;
`endif
    start[k] = 1'b1;
    tick();
    start[k] = 1'b0;
  endtask

  task automatic push(input int k, input logic [31:0] d);
    wr_t w;
    w.addr = exp_addr[k];
    w.data = d;
    if (k == 0) q_a.push_back(w);
    else        q_b.push_back(w);
    exp_addr[k]++;
`ifdef LOADER_CHECKSUM_EN
    sum_model[k] = sum_model[k] + d;
    exp_sum[k]   = sum_model[k];
`endif
  endtask

  task automatic send_word(input int k, input logic [31:0] d, input int budget, output bit acc);
    int n = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    while (!in_ready[k] && n < budget) begin
      tick();
      n++;
    end
    acc = in_ready[k];
    if (acc) begin
      push(k, d);
      tick();
    end
    in_valid[k] = 1'b0;
  endtask

  task automatic send_ok(input int k, input logic [31:0] d);
    bit acc;
    send_word(k, d, 20, acc);
    check("word_accepted", 32'(acc), 1);
  endtask

  task automatic reset_vals(input int k, input string tag);
    check({tag, "_flags"}, 32'({in_ready[k], imem_we[k], core_hold[k], core_start[k],
                                busy[k], done[k], err[k]}), 32'h10);
    check({tag, "_addr"}, addr_of(k), 0);
    check({tag, "_wdata"}, wdata[k], 0);
    check({tag, "_wc"}, wc_of(k), 0);
  endtask

  // Entered one cycle after the HLT transfer, i.e. in DRAIN.
  task automatic finish_load(input int k, input string tag);
    check({tag, "_drain_in_ready"}, 32'(in_ready[k]), 0);
    check({tag, "_drain_hold"}, 32'(core_hold[k]), 1);
    tick();
    check({tag, "_release_start"}, 32'(core_start[k]), 1);
    check({tag, "_release_hold"}, 32'(core_hold[k]), 0);
    tick();
    check({tag, "_run_done"}, 32'(done[k]), 1);
    check({tag, "_run_hold"}, 32'(core_hold[k]), 0);
    check({tag, "_run_start"}, 32'(core_start[k]), 0);
    check({tag, "_run_busy"}, 32'(busy[k]), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int st_before;
    in_data[0] = '0;
    in_data[1] = '0;
`ifdef LOADER_CHECKSUM_EN
    exp_sum[0] = '0;
    exp_sum[1] = '0;
    sum_model[0] = '0;
    sum_model[1] = '0;
`endif
    tick();
    tick();
    reset_vals(0, "rst_a");
    reset_vals(1, "rst_b");
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready[0]), 0);
    check("idle_hold", 32'(core_hold[0]), 1);

    // Ten-word program ending in HLT.
    pulse_start(0);
    check("load_in_ready", 32'(in_ready[0]), 1);
    check("load_busy", 32'(busy[0]), 1);
    check("load_hold", 32'(core_hold[0]), 1);
    check("load_wc", wc_of(0), 0);
    for (int i = 0; i < 10; i++) send_ok(0, prog10[i]);
    finish_load(0, "p10");
    check("p10_wc", wc_of(0), 10);
    check("p10_starts", starts[0], 1);

    // Stream traffic in RUN must not be taken.
    in_valid[0] = 1'b1;
    in_data[0]  = 32'hdeadbeef;
    tick();
    tick();
    in_valid[0] = 1'b0;
    check("run_ignore_done", 32'(done[0]), 1);
    check("run_ignore_wc", wc_of(0), 10);

    // Restart from RUN, then three words with gaps and a stray start.
    pulse_start(0);
    check("reload_hold", 32'(core_hold[0]), 1);
    check("reload_done", 32'(done[0]), 0);
    check("reload_wc", wc_of(0), 0);
    check("reload_in_ready", 32'(in_ready[0]), 1);
    send_ok(0, 32'h00000013);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    send_ok(0, 32'h00100093);
    tick();
    send_ok(0, 32'hfe000000);
    finish_load(0, "gap");
    check("gap_wc", wc_of(0), 3);
    check("gap_starts", starts[0], 2);

    // Reset in the middle of a load, then a short reload.
    pulse_start(0);
    for (int i = 0; i < 4; i++) send_ok(0, 32'h11111111 * (i + 1));
    tick();
    rst = 1'b1;
    #1;
    reset_vals(0, "midrst");
    tick();
    reset_vals(0, "midrst_hold");
    rst = 1'b0;
    tick();
    pulse_start(0);
    send_ok(0, 32'h22222222);
    send_ok(0, 32'hfe000000);
    finish_load(0, "after_rst");
    check("after_rst_wc", wc_of(0), 2);

    // Small instance: eight plain words overflow the memory.
    pulse_start(1);
    for (int i = 0; i < 8; i++) send_ok(1, 32'h00000013 + 32'(i) * 32'h100);
    check("ovf_err", 32'(err[1]), 1);
    check("ovf_in_ready", 32'(in_ready[1]), 0);
    check("ovf_hold", 32'(core_hold[1]), 1);
    check("ovf_busy", 32'(busy[1]), 0);
    check("ovf_wc", wc_of(1), 8);
    send_word(1, 32'h00000033, 5, acc);
    check("ovf_refused", 32'(acc), 0);
    check("ovf_err_kept", 32'(err[1]), 1);
    check("ovf_hold_kept", 32'(core_hold[1]), 1);
    check("ovf_no_start", starts[1], 0);

    // start leaves ERR and restarts at address 0.
    pulse_start(1);
    check("errexit_err", 32'(err[1]), 0);
    check("errexit_in_ready", 32'(in_ready[1]), 1);
    check("errexit_wc", wc_of(1), 0);
    send_ok(1, 32'hfe000000);
    finish_load(1, "errexit");
    check("errexit_wc_end", wc_of(1), 1);
    check("errexit_starts", starts[1], 1);

`ifdef LOADER_CHECKSUM_EN
    pulse_start(0);
    send_ok(0, 32'h1400800a);
    send_ok(0, 32'hfe000000);
    exp_sum[0] = 32'h1200800a;
    check("cks_value", cks[0], 32'h1200800a);
    finish_load(0, "cks_ok");

    st_before = starts[0];
    pulse_start(0);
    send_ok(0, 32'h1400800a);
    send_ok(0, 32'hfe000000);
    exp_sum[0] = 32'h1200800b;
    check("cks_bad_value", cks[0], 32'h1200800a);
    tick();
    check("cks_bad_err", 32'(err[0]), 1);
    check("cks_bad_hold", 32'(core_hold[0]), 1);
    tick();
    check("cks_bad_no_start", starts[0], st_before);
`else
    st_before = starts[0];
    tick();
    check("quiet_starts", starts[0], st_before);
`endif

    tick();
    tick();
    check("queue_a_empty", q_a.size(), 0);
    check("queue_b_empty", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the instruction-memory word-address width.
REQ-002 SHALL have parameter HLT_OPCODE, default 7'h7f, the opcode value in instruction bits [31:25] that terminates a load.
REQ-003 SHALL have port clk1  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a load, sampled per cycle.
REQ-006 SHALL have ports in_valid  input  1, in_ready  output  1, in_data  input  32  instruction-word stream; transfer when both valid and ready are high at a rising edge.
REQ-007 SHALL have ports imem_we  output  1, imem_addr  output  ADDR_W, imem_wdata  output  32  instruction-memory write port.
REQ-008 SHALL have port core_hold  output  1  holds the core halted with PC=0 and TAKEN_BRANCH=0 while high.
REQ-009 SHALL have port core_start  output  1  one-cycle release pulse to the core.
REQ-010 SHALL have ports busy, done, err  output  1 each, and word_count  output  ADDR_W+1  number of words accepted in the current load.

Function
REQ-011 SHALL implement states IDLE, LOAD, DRAIN, RELEASE, RUN, ERR; all outputs registered.
REQ-012 IDLE: in_ready=0, core_hold=1; start=1 moves to LOAD with address and word_count cleared to 0.
REQ-013 LOAD: in_ready=1, busy=1; each transfer increments word_count by 1 and, in the next cycle, drives imem_we=1, imem_addr=index of the word, and imem_wdata=in_data.
REQ-014 Addresses SHALL be contiguous from 0 with no duplicate or skipped writes, regardless of in_valid gaps.
REQ-015 A transfer whose in_data[31:25]==HLT_OPCODE SHALL be written and SHALL move the FSM to DRAIN; in_ready drops in the following cycle.
REQ-016 DRAIN SHALL last one cycle, covering the final write, and then move to RELEASE.
REQ-017 RELEASE SHALL assert core_start=1 and core_hold=0 for exactly one cycle and then move to RUN.
REQ-018 RUN: core_hold=0, done=1, in_ready=0; start=1 moves to LOAD, and core_hold returns to 1 in the next cycle.
REQ-019 If word_count reaches 2**ADDR_W without an HLT word, the FSM SHALL move to ERR; no further words are accepted.
REQ-020 ERR: err=1, core_hold=1, in_ready=0, no core_start; only start or rst exits (start moves to LOAD).
REQ-021 start SHALL be ignored in LOAD, DRAIN and RELEASE; in_valid SHALL be ignored outside LOAD.

Reset
REQ-022 rst SHALL immediately force state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, core_start=0, busy=0, done=0, err=0 and word_count=0.
REQ-023 Reset mid-load SHALL leave the partially written memory image as is; the next load SHALL restart at address 0.

Configuration
REQ-024 With macro LOADER_CHECKSUM_EN defined, the block SHALL add input expected_sum (32) and output checksum (32), the wrapping 32-bit sum of all accepted words including the HLT word.
REQ-025 With LOADER_CHECKSUM_EN defined, DRAIN SHALL compare checksum to expected_sum and move to ERR on mismatch instead of RELEASE.
REQ-026 Without LOADER_CHECKSUM_EN, the expected_sum and checksum ports and the comparison SHALL be absent.

Structure
REQ-027 Shared package riscv32_pkg SHALL hold the 32-bit word width, the HLT opcode constant 7'h7f and the loader state enumeration.
REQ-028 The checksum accumulator SHALL be sub-module loader_cksum, instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-029 Stream 10 words 0x1400800a, 0x14010014, ... ending 0xfe000000 -> writes to addresses 0..9, word_count=10, one core_start pulse, then core_hold=0 and done=1.
REQ-030 Send 3 words (last is HLT) with in_valid high every other cycle -> writes to addresses 0,1,2 only, each exactly once.
REQ-031 With ADDR_W=3, send 8 non-HLT words -> err=1 after the 8th, in_ready=0, 9th word refused, core_hold stays 1, no core_start.
REQ-032 Assert rst after 4 words, then start and send 2 words (last HLT) -> all outputs at reset values during rst; new writes at addresses 0 and 1.
REQ-033 Pulse start in RUN -> core_hold=1 in the next cycle; reload begins at address 0.
REQ-034 With LOADER_CHECKSUM_EN, send 0x1400800a, 0xfe000000 with expected_sum=0x1200800a -> release; with expected_sum=0x1200800b -> err=1, no core_start.
